// File: rtl/aurora_tx_arb_pkg.sv
// Shared definitions for the Aurora TX packet arbiter: FSM encoding and default widths.
package aurora_tx_arb_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_DW      = 64;
    localparam int DEF_KW      = DEF_DW / 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping at N.
module rr_prio_pick #(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] ptr_i,
    output logic [GW-1:0] grant_o,
    output logic          any_req_o
);

    logic [GW-1:0] idx_s;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % N;
        return GW'(s);
    endfunction

    // Walk from the farthest candidate back towards ptr+1 so the nearest requester overwrites last.
    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx_s     = '0;
        for (int k = N; k >= 1; k--) begin
            idx_s     = wrap_idx(ptr_i, k);
            grant_o   = req_i[idx_s] ? idx_s : grant_o;
            any_req_o = any_req_o | req_i[idx_s];
        end
    end

endmodule

// File: rtl/aurora_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Aurora 64B/66B TX AXI4-Stream port.
// A grant is held from first beat to tlast; a channel_up loss drains and discards the cut packet.
module aurora_tx_pkt_arbiter
    import aurora_tx_arb_pkg::*;
#(
    parameter  int NUM_SRC = DEF_NUM_SRC,
    parameter  int DW      = DEF_DW,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int KW      = DW / 8,
    localparam int GW      = $clog2(NUM_SRC)
) (
    input  logic                  user_clk,
    input  logic                  system_rst,
    input  logic                  channel_up,
    input  logic [NUM_SRC*DW-1:0] s_tdata,
    input  logic [NUM_SRC*KW-1:0] s_tkeep,
    input  logic [NUM_SRC-1:0]    s_tlast,
    input  logic [NUM_SRC-1:0]    s_tvalid,
    output logic [NUM_SRC-1:0]    s_tready,
    output logic [DW-1:0]         m_tdata,
    output logic [KW-1:0]         m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    logic [1:0]       rst_sync_q;
    logic             rst;
    arb_state_e       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [GW-1:0]    pick_s;
    logic             any_req_s;
    logic             sel_valid_s;
    logic             sel_last_s;

    // Reset asserts immediately and is released two user_clk edges after system_rst falls.
    always_ff @(posedge user_clk or posedge system_rst) begin
        if (system_rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    rr_prio_pick #(
        .N  (NUM_SRC),
        .GW (GW)
    ) u_pick (
        .req_i     (s_tvalid),
        .ptr_i     (ptr_q),
        .grant_o   (pick_s),
        .any_req_o (any_req_s)
    );

    assign sel_valid_s = s_tvalid[grant_q];
    assign sel_last_s  = s_tlast[grant_q];
    assign m_tdata     = s_tdata[int'(grant_q)*DW +: DW];
    assign m_tkeep     = s_tkeep[int'(grant_q)*KW +: KW];
    assign m_tlast     = sel_last_s;
    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign pkt_cnt     = pkt_cnt_q;
    assign drop_cnt    = drop_cnt_q;

    // Next-state, handshake steering and counter updates.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        m_tvalid   = 1'b0;
        s_tready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (channel_up && (|s_tvalid)) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (any_req_s) begin
                    grant_d = pick_s;
                    ptr_d   = pick_s;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                m_tvalid          = sel_valid_s & channel_up;
                s_tready[grant_q] = m_tready & channel_up;
                // A tlast handshake wins over a simultaneous link drop: the beat already went out.
                if (sel_valid_s && channel_up && m_tready && sel_last_s) begin
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end else if (!channel_up) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DRAIN: begin
                s_tready[grant_q] = 1'b1;
                if (sel_valid_s && sel_last_s) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and statistics registers.
    always_ff @(posedge user_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= GW'(NUM_SRC - 1);
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_aurora_tx_pkt_arbiter.sv
// Bench for aurora_tx_pkt_arbiter: directed link/reset scenarios plus randomized traffic
// checked against a packet-level round-robin reference model.
module tb_aurora_tx_pkt_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DW      = 64;
    localparam int KW      = DW / 8;
    localparam int CNT_W   = 16;
    localparam int GW      = 2;
    localparam int MAXP    = 16;

    logic                  user_clk   = 1'b0;
    logic                  system_rst = 1'b0;
    logic                  channel_up = 1'b0;
    logic [NUM_SRC*DW-1:0] s_tdata    = '0;
    logic [NUM_SRC*KW-1:0] s_tkeep    = '0;
    logic [NUM_SRC-1:0]    s_tlast    = '0;
    logic [NUM_SRC-1:0]    s_tvalid   = '0;
    logic [NUM_SRC-1:0]    s_tready;
    logic [DW-1:0]         m_tdata;
    logic [KW-1:0]         m_tkeep;
    logic                  m_tlast;
    logic                  m_tvalid;
    logic                  m_tready   = 1'b0;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic [CNT_W-1:0]      pkt_cnt;
    logic [CNT_W-1:0]      drop_cnt;

    always #5 user_clk = ~user_clk;

    aurora_tx_pkt_arbiter #(
        .NUM_SRC (NUM_SRC),
        .DW      (DW),
        .CNT_W   (CNT_W)
    ) dut (
        .user_clk   (user_clk),
        .system_rst (system_rst),
        .channel_up (channel_up),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .grant_id   (grant_id),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Source drivers and reference-model state.
    int   len_tab [NUM_SRC][MAXP];
    int   lim     [NUM_SRC];
    int   drv_seq [NUM_SRC];
    int   drv_beat[NUM_SRC];
    bit   drv_act [NUM_SRC];
    int   hs_cnt  [NUM_SRC];
    int   exp_seq [NUM_SRC];
    int   exp_beat, cur, mptr, done_pkts, exp_drops;
    bit   in_pkt, checking, drop_mode, expect_idle, lat_arm;
    int   order_log[$];
    int   start_pct, rdy_pct;
    int   cyc, lat_start, lat;
    logic [NUM_SRC-1:0] prev_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pkt_len(input int src, input int seq);
        return len_tab[src][seq % MAXP];
    endfunction

    function automatic logic [DW-1:0] beat_data(input int src, input int seq, input int beat);
        return {8'(src), 8'(seq), 8'(beat), 8'hA5, 32'((src * 32'h0101_0101) ^ (seq * 977) ^ (beat * 31))};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int src, input int seq, input int beat);
        logic [KW-1:0] full;
        full = '1;
        return (beat == pkt_len(src, seq) - 1) ? (full >> ((src + seq) % KW)) : full;
    endfunction

    // First pending source after the last one served, wrapping around.
    function automatic int rr_expect(input logic [NUM_SRC-1:0] v, input int p);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (v[(p + k) % NUM_SRC]) return (p + k) % NUM_SRC;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tvalid[i]         = drv_act[i];
            s_tdata[i*DW +: DW] = beat_data(i, drv_seq[i], drv_beat[i]);
            s_tkeep[i*KW +: KW] = beat_keep(i, drv_seq[i], drv_beat[i]);
            s_tlast[i]          = drv_act[i] && (drv_beat[i] == pkt_len(i, drv_seq[i]) - 1);
        end
    endtask

    task automatic bench_reset_state();
        for (int i = 0; i < NUM_SRC; i++) begin
            lim[i] = 0; drv_seq[i] = 0; drv_beat[i] = 0; drv_act[i] = 0;
            hs_cnt[i] = 0; exp_seq[i] = 0;
            for (int j = 0; j < MAXP; j++) len_tab[i][j] = 1 + $urandom_range(4);
        end
        exp_beat = 0; cur = 0; in_pkt = 0; mptr = NUM_SRC - 1;
        done_pkts = 0; exp_drops = 0; order_log.delete();
        checking = 1; drop_mode = 0; expect_idle = 0; lat_arm = 0;
        lat_start = -1; lat = -1; prev_valid = '0;
    endtask

    task automatic model_observe();
        logic [NUM_SRC-1:0] er;
        int pick;
        int plen;
        bit mbeat;
        mbeat = m_tvalid && m_tready;
        if (drop_mode) begin
            er = ~(NUM_SRC'(1) << cur);
            check_eq("drop_mvalid", m_tvalid, 0);
            check_eq("drop_other_ready", s_tready & er, 0);
            return;
        end
        if (!checking) return;
        if (!in_pkt && expect_idle) begin
            check_eq("down_busy", busy, 0);
            check_eq("down_mvalid", m_tvalid, 0);
        end
        if (!in_pkt && m_tvalid) begin
            pick = rr_expect(prev_valid, mptr);
            check_eq("grant_id", grant_id, pick);
            if (pick < 0) pick = 0;
            cur = pick; mptr = pick; in_pkt = 1; exp_beat = 0;
            order_log.push_back(pick);
            if (lat_arm) begin
                lat = cyc - lat_start;
                lat_arm = 0;
            end
        end
        if (in_pkt) begin
            plen = pkt_len(cur, exp_seq[cur]);
            er   = m_tready ? (NUM_SRC'(1) << cur) : '0;
            check_eq("busy", busy, 1);
            check_eq("mvalid_held", m_tvalid, 1);
            check_eq("s_tready", s_tready, er);
            check_eq("m_tdata", m_tdata, beat_data(cur, exp_seq[cur], exp_beat));
            check_eq("m_tkeep", m_tkeep, beat_keep(cur, exp_seq[cur], exp_beat));
            check_eq("m_tlast", m_tlast, exp_beat == plen - 1);
            if (mbeat) begin
                if (exp_beat == plen - 1) begin
                    exp_seq[cur]++;
                    in_pkt = 0;
                    done_pkts++;
                end else begin
                    exp_beat++;
                end
            end
        end else begin
            check_eq("idle_ready", s_tready, 0);
        end
    endtask

    // One clock: observe at the falling edge, then update the sources after the rising edge.
    task automatic tick();
        logic [NUM_SRC-1:0] hs;
        @(negedge user_clk);
        hs = s_tvalid & s_tready;
        model_observe();
        prev_valid = s_tvalid;
        @(posedge user_clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) begin
                hs_cnt[i]++;
                if (drv_beat[i] == pkt_len(i, drv_seq[i]) - 1) begin
                    drv_act[i] = 0;
                    drv_seq[i]++;
                end else begin
                    drv_beat[i]++;
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!drv_act[i] && drv_seq[i] < lim[i] && $urandom_range(99) < start_pct) begin
                drv_act[i]  = 1;
                drv_beat[i] = 0;
                if (lat_start < 0) lat_start = cyc;
            end
        end
        m_tready = ($urandom_range(99) < rdy_pct);
        drive_inputs();
    endtask

    task automatic run_phase(input int target, input int budget);
        int n;
        n = 0;
        while (done_pkts < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("phase_done", done_pkts, target);
    endtask

    task automatic do_reset();
        system_rst = 1'b1;
        bench_reset_state();
        m_tready = 1'b0;
        drive_inputs();
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        check_eq("rst_mvalid", m_tvalid, 0);
        check_eq("rst_ready", s_tready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_pkt_cnt", pkt_cnt, 0);
        check_eq("rst_drop_cnt", drop_cnt, 0);
        @(posedge user_clk);
        #1;
        system_rst = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
    endtask

    initial begin
        int n;
        cyc = 0; start_pct = 100; rdy_pct = 100;
        bench_reset_state();
        #2;
        do_reset();

        // Single 3-beat packet from src0: two-cycle latency, grant 0.
        channel_up = 1'b1;
        lim[0] = 1; len_tab[0][0] = 3; lat_start = -1; lat_arm = 1;
        run_phase(1, 50);
        check_eq("t1_latency", lat, 2);
        check_eq("t1_grant", grant_id, 0);
        check_eq("t1_pkt_cnt", pkt_cnt, 1);

        // All sources continuously pending with 2-beat packets: strict rotation from src0.
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            lim[i] = 2; len_tab[i][0] = 2; len_tab[i][1] = 2;
        end
        run_phase(8, 200);
        if (order_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) check_eq($sformatf("t2_order%0d", k), order_log[k], k % NUM_SRC);
        end else begin
            check_eq("t2_order_len", order_log.size(), 5);
        end
        check_eq("t2_pkt_cnt", pkt_cnt, 8);

        // Randomized arrivals, lengths and back-pressure.
        for (int i = 0; i < NUM_SRC; i++) lim[i] = 8;
        start_pct = 40; rdy_pct = 70;
        run_phase(32, 4000);
        check_eq("rand_pkt_cnt", pkt_cnt, 32);
        check_eq("rand_drop_cnt", drop_cnt, 0);

        // Link drop after beat 2 of a 6-beat packet from src1.
        start_pct = 100; rdy_pct = 100;
        len_tab[1][8] = 6; lim[1] = 9;
        n = 0;
        while (!(in_pkt && cur == 1 && exp_beat == 2) && n < 50) begin
            tick();
            n++;
        end
        check_eq("t4_reach_beat2", exp_beat, 2);
        channel_up = 1'b0; drop_mode = 1; hs_cnt[1] = 0;
        n = 0;
        while (drv_seq[1] < 9 && n < 30) begin
            tick();
            n++;
        end
        drop_mode = 0;
        check_eq("t4_drained", hs_cnt[1], 4);
        in_pkt = 0; exp_seq[1]++; exp_drops++;
        check_eq("t4_drop_cnt", drop_cnt, exp_drops);
        check_eq("t4_pkt_cnt", pkt_cnt, 32);

        // Channel down with a pending source: stays idle, then two-cycle start after channel_up.
        len_tab[3][8] = 2; lim[3] = 9; expect_idle = 1;
        repeat (6) tick();
        check_eq("t5_idle_busy", busy, 0);
        channel_up = 1'b1; expect_idle = 0; lat_start = cyc; lat_arm = 1;
        run_phase(33, 50);
        check_eq("t5_latency", lat, 2);
        check_eq("t5_grant", grant_id, 3);

        // Reset in the middle of a packet from src0, then full contention from reset.
        len_tab[0][8] = 5; lim[0] = 9;
        n = 0;
        while (!(in_pkt && cur == 0 && exp_beat == 1) && n < 50) begin
            tick();
            n++;
        end
        check_eq("t6_reach_beat1", exp_beat, 1);
        system_rst = 1'b1;
        #1;
        check_eq("t6_mvalid", m_tvalid, 0);
        check_eq("t6_ready", s_tready, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_grant", grant_id, 0);
        check_eq("t6_pkt_cnt", pkt_cnt, 0);
        check_eq("t6_drop_cnt", drop_cnt, 0);
        bench_reset_state();
        drive_inputs();
        repeat (2) @(posedge user_clk);
        #1;
        system_rst = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            lim[i] = 1; len_tab[i][0] = 2;
        end
        run_phase(4, 100);
        if (order_log.size() >= 1) begin
            check_eq("t6_first_grant", order_log[0], 0);
        end else begin
            check_eq("t6_order_len", order_log.size(), 1);
        end
        check_eq("t6_post_pkt_cnt", pkt_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
